// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multi-cycle RV32I control FSM.
// Sequences FETCH/DECODE/EXEC/MEM/WB over a variable-latency memory, with a
// memory-timeout fault halt. Optional performance counters are built only when
// the macro MC_PERF_CNT_EN is defined; otherwise both counters are tied to 0.
module multicycle_ctrl #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [6:0]           opcode,
  input  logic [2:0]           funct3,
  input  logic                 br_taken,
  input  logic                 mem_ready,
  output logic                 inst_req,
  output logic                 ir_we,
  output logic                 data_req,
  output logic                 data_we,
  output logic                 rf_we,
  output logic [1:0]           wb_sel,
  output logic                 pc_we,
  output logic [1:0]           pc_sel,
  output logic                 halt,
  output logic                 fault,
  output logic [2:0]           state,
  output logic [CNT_WIDTH-1:0] cycle_cnt,
  output logic [CNT_WIDTH-1:0] instret_cnt
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  // Timeout fires on the waiting cycle that would bring the count to MEM_TIMEOUT.
  localparam logic [7:0] TMO_LAST = 8'(MEM_TIMEOUT - 1);

  state_t     state_reg, state_next;
  logic [7:0] tmo_reg, tmo_next;
  logic       fault_reg, fault_next;

  logic is_load, is_store, is_branch, is_lui_auipc, is_jal, is_jalr, is_alu;
  logic legal;
  logic waiting, timeout_hit;

  // Instruction class decode from IR fields (IR is stable from DECODE onward).
  always_comb begin
    is_load      = (opcode == OPC_LOAD);
    is_store     = (opcode == OPC_STORE);
    is_branch    = (opcode == OPC_BRANCH);
    is_lui_auipc = (opcode == OPC_LUI) || (opcode == OPC_AUIPC);
    is_jal       = (opcode == OPC_JAL);
    is_jalr      = (opcode == OPC_JALR);
    is_alu       = (opcode == OPC_OP) || (opcode == OPC_OPIMM);
    legal        = is_alu || is_lui_auipc || is_jal || is_jalr
                 || (is_branch && (funct3 != 3'b010) && (funct3 != 3'b011))
                 || (is_load && (funct3 != 3'b011) && (funct3 < 3'b110))
                 || (is_store && (funct3 < 3'b011));
  end

  // Next-state and Mealy output decode; reset forces every strobe low.
  always_comb begin
    state_next  = state_reg;
    fault_next  = fault_reg;
    inst_req    = 1'b0;
    ir_we       = 1'b0;
    data_req    = 1'b0;
    data_we     = 1'b0;
    rf_we       = 1'b0;
    wb_sel      = 2'b00;
    pc_we       = 1'b0;
    pc_sel      = 2'b00;
    waiting     = ((state_reg == S_FETCH) || (state_reg == S_MEM)) && !mem_ready;
    timeout_hit = waiting && (tmo_reg == TMO_LAST);
    tmo_next    = waiting ? tmo_reg + 8'd1 : 8'd0;

    case (state_reg)
      S_FETCH: begin
        inst_req = 1'b1;
        if (mem_ready) begin
          ir_we      = 1'b1;
          state_next = S_DECODE;
        end else if (timeout_hit) begin
          state_next = S_HALT;
          fault_next = 1'b1;
        end
      end
      S_DECODE: begin
        state_next = legal ? S_EXEC : S_HALT;
      end
      S_EXEC: begin
        if (is_load || is_store) begin
          state_next = S_MEM;
        end else if (is_branch) begin
          pc_we      = 1'b1;
          pc_sel     = br_taken ? 2'b01 : 2'b00;
          state_next = S_FETCH;
        end else begin
          state_next = S_WB;
        end
      end
      S_MEM: begin
        data_req = 1'b1;
        data_we  = is_store;
        if (mem_ready) begin
          if (is_load) begin
            state_next = S_WB;
          end else begin
            pc_we      = 1'b1;
            state_next = S_FETCH;
          end
        end else if (timeout_hit) begin
          state_next = S_HALT;
          fault_next = 1'b1;
        end
      end
      S_WB: begin
        rf_we      = 1'b1;
        pc_we      = 1'b1;
        state_next = S_FETCH;
        if (is_load) begin
          wb_sel = 2'b01;
        end else if (is_lui_auipc) begin
          wb_sel = 2'b11;
        end else if (is_jal) begin
          wb_sel = 2'b10;
          pc_sel = 2'b10;
        end else if (is_jalr) begin
          wb_sel = 2'b10;
          pc_sel = 2'b11;
        end
      end
      S_HALT: begin
        state_next = S_HALT;
      end
      default: begin
        state_next = S_HALT;
      end
    endcase

    // An access in flight when reset arrives is abandoned without side effects.
    if (rst) begin
      inst_req = 1'b0;
      ir_we    = 1'b0;
      data_req = 1'b0;
      data_we  = 1'b0;
      rf_we    = 1'b0;
      wb_sel   = 2'b00;
      pc_we    = 1'b0;
      pc_sel   = 2'b00;
    end
  end

  // State, timeout counter and sticky fault registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_FETCH;
      tmo_reg   <= 8'd0;
      fault_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      tmo_reg   <= tmo_next;
      fault_reg <= fault_next;
    end
  end

  assign state = state_reg;
  assign halt  = (state_reg == S_HALT);
  assign fault = fault_reg;

`ifdef MC_PERF_CNT_EN
  logic [CNT_WIDTH-1:0] cycle_reg, instret_reg;

  // Performance counters: run outside reset and HALT, wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_reg   <= '0;
      instret_reg <= '0;
    end else if (state_reg != S_HALT) begin
      cycle_reg <= cycle_reg + 1'b1;
      if (pc_we) begin
        instret_reg <= instret_reg + 1'b1;
      end
    end
  end

  assign cycle_cnt   = cycle_reg;
  assign instret_cnt = instret_reg;
`else
  assign cycle_cnt   = '0;
  assign instret_cnt = '0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: directed-vector bench with a scoreboard queue.
// Stimulus drives one cycle of inputs and pushes that cycle's expected outputs;
// a negedge monitor pops and compares. Output vector layout:
// {inst_req, ir_we, data_req, data_we, rf_we, pc_we, wb_sel, pc_sel, halt, fault}.
module tb_multicycle_ctrl;

  localparam logic [6:0] OP   = 7'b0110011;
  localparam logic [6:0] LD   = 7'b0000011;
  localparam logic [6:0] ST   = 7'b0100011;
  localparam logic [6:0] BR   = 7'b1100011;
  localparam logic [6:0] LUI  = 7'b0110111;
  localparam logic [6:0] JAL  = 7'b1101111;
  localparam logic [6:0] JALR = 7'b1100111;
  localparam logic [6:0] SYS  = 7'b1110011;

  logic        clk = 1'b0;
  logic        rst, br_taken, mem_ready;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        inst_req, ir_we, data_req, data_we, rf_we, pc_we, halt, fault;
  logic [1:0]  wb_sel, pc_sel;
  logic [2:0]  state;
  logic [31:0] cycle_cnt, instret_cnt;

  typedef struct {
    string       name;
    logic [2:0]  st;
    logic [11:0] vec;
    logic [31:0] cyc;
    logic [31:0] ins;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] m_cyc = 0;
  logic [31:0] m_ins = 0;

  multicycle_ctrl #(.MEM_TIMEOUT(4), .CNT_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3),
    .br_taken(br_taken), .mem_ready(mem_ready),
    .inst_req(inst_req), .ir_we(ir_we), .data_req(data_req), .data_we(data_we),
    .rf_we(rf_we), .wb_sel(wb_sel), .pc_we(pc_we), .pc_sel(pc_sel),
    .halt(halt), .fault(fault), .state(state),
    .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
  );

  always #5 clk = ~clk;

  // One cycle: drive inputs, push expectation, advance to just after the next edge.
  task automatic step(input string nm, input logic r, input logic [6:0] opc,
                      input logic [2:0] f3, input logic br, input logic mr,
                      input logic [2:0] es, input logic [5:0] estr,
                      input logic [1:0] ewb, input logic [1:0] epc, input logic [1:0] ehf);
    exp_t e;
    rst = r; opcode = opc; funct3 = f3; br_taken = br; mem_ready = mr;
    e.name = nm;
    e.st   = es;
    e.vec  = {estr, ewb, epc, ehf};
`ifdef MC_PERF_CNT_EN
    e.cyc = m_cyc;
    e.ins = m_ins;
`else
    e.cyc = 32'd0;
    e.ins = 32'd0;
`endif
    sb.push_back(e);
    if (r) begin
      m_cyc = 0;
      m_ins = 0;
    end else if (es != 3'd5) begin
      m_cyc = m_cyc + 1;
      if (estr[0]) m_ins = m_ins + 1;
    end
    @(posedge clk);
    #1;
  endtask

  // FETCH (memory ready) followed by DECODE for a legal instruction.
  task automatic fd(input string nm, input logic [6:0] opc, input logic [2:0] f3);
    step({nm, "_fetch"}, 0, opc, f3, 0, 1, 3'd0, 6'b110000, 2'b00, 2'b00, 2'b00);
    step({nm, "_decode"}, 0, opc, f3, 0, 1, 3'd1, 6'b000000, 2'b00, 2'b00, 2'b00);
  endtask

  // Monitor: compare outputs against the oldest expectation each cycle.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      logic [11:0] act;
      e = sb.pop_front();
      act = {inst_req, ir_we, data_req, data_we, rf_we, pc_we, wb_sel, pc_sel, halt, fault};
      n_cmp++;
      if (state !== e.st || act !== e.vec) begin
        n_bad++;
        $display("FAIL %s: state=%0d outs=%b, required state=%0d outs=%b",
                 e.name, state, act, e.st, e.vec);
      end
      n_cmp++;
      if (cycle_cnt !== e.cyc || instret_cnt !== e.ins) begin
        n_bad++;
        $display("FAIL %s_cnt: cycle=%0d instret=%0d, required cycle=%0d instret=%0d",
                 e.name, cycle_cnt, instret_cnt, e.cyc, e.ins);
      end
    end
  end

  initial begin
    rst = 1; opcode = OP; funct3 = 3'd0; br_taken = 0; mem_ready = 1;
    @(posedge clk);
    #1;

    // 1: reset then ALU instruction, 4 cycles, retire in WB
    step("t1_rst", 1, OP, 0, 0, 1, 3'd0, 6'b000000, 2'b00, 2'b00, 2'b00);
    fd("t1_alu", OP, 3'd0);
    step("t1_exec", 0, OP, 0, 0, 1, 3'd2, 6'b000000, 2'b00, 2'b00, 2'b00);
    step("t1_wb", 0, OP, 0, 0, 1, 3'd4, 6'b000011, 2'b00, 2'b00, 2'b00);

    // 2: branch taken / not taken retire from EXEC
    fd("t2_bt", BR, 3'd0);
    step("t2_bt_exec", 0, BR, 0, 1, 1, 3'd2, 6'b000001, 2'b00, 2'b01, 2'b00);
    fd("t2_bn", BR, 3'd0);
    step("t2_bn_exec", 0, BR, 0, 0, 1, 3'd2, 6'b000001, 2'b00, 2'b00, 2'b00);

    // 3: load with 3 wait cycles in MEM, then store
    fd("t3_ld", LD, 3'd2);
    step("t3_ld_exec", 0, LD, 2, 0, 1, 3'd2, 6'b000000, 2'b00, 2'b00, 2'b00);
    for (int i = 0; i < 3; i++)
      step("t3_ld_memwait", 0, LD, 2, 0, 0, 3'd3, 6'b001000, 2'b00, 2'b00, 2'b00);
    step("t3_ld_mem", 0, LD, 2, 0, 1, 3'd3, 6'b001000, 2'b00, 2'b00, 2'b00);
    step("t3_ld_wb", 0, LD, 2, 0, 1, 3'd4, 6'b000011, 2'b01, 2'b00, 2'b00);
    fd("t3_st", ST, 3'd2);
    step("t3_st_exec", 0, ST, 2, 0, 1, 3'd2, 6'b000000, 2'b00, 2'b00, 2'b00);
    step("t3_st_mem", 0, ST, 2, 0, 1, 3'd3, 6'b001101, 2'b00, 2'b00, 2'b00);

    // writeback selects for LUI, JAL, JALR
    fd("lui", LUI, 3'd0);
    step("lui_exec", 0, LUI, 0, 0, 1, 3'd2, 6'b000000, 2'b00, 2'b00, 2'b00);
    step("lui_wb", 0, LUI, 0, 0, 1, 3'd4, 6'b000011, 2'b11, 2'b00, 2'b00);
    fd("jal", JAL, 3'd0);
    step("jal_exec", 0, JAL, 0, 0, 1, 3'd2, 6'b000000, 2'b00, 2'b00, 2'b00);
    step("jal_wb", 0, JAL, 0, 0, 1, 3'd4, 6'b000011, 2'b10, 2'b10, 2'b00);
    fd("jalr", JALR, 3'd0);
    step("jalr_exec", 0, JALR, 0, 0, 1, 3'd2, 6'b000000, 2'b00, 2'b00, 2'b00);
    step("jalr_wb", 0, JALR, 0, 0, 1, 3'd4, 6'b000011, 2'b10, 2'b11, 2'b00);

    // boundary: mem_ready arrives on the limit cycle, access wins
    for (int i = 0; i < 3; i++)
      step("lim_fetchwait", 0, OP, 0, 0, 0, 3'd0, 6'b100000, 2'b00, 2'b00, 2'b00);
    step("lim_fetch", 0, OP, 0, 0, 1, 3'd0, 6'b110000, 2'b00, 2'b00, 2'b00);
    step("lim_decode", 0, OP, 0, 0, 1, 3'd1, 6'b000000, 2'b00, 2'b00, 2'b00);
    step("lim_exec", 0, OP, 0, 0, 1, 3'd2, 6'b000000, 2'b00, 2'b00, 2'b00);
    step("lim_wb", 0, OP, 0, 0, 1, 3'd4, 6'b000011, 2'b00, 2'b00, 2'b00);

    // 5: illegal opcode and illegal branch funct3 halt without fault
    fd("t5_sys", SYS, 3'd0);
    step("t5_sys_halt", 0, SYS, 0, 0, 1, 3'd5, 6'b000000, 2'b00, 2'b00, 2'b10);
    step("t5_sys_hold", 0, SYS, 0, 0, 1, 3'd5, 6'b000000, 2'b00, 2'b00, 2'b10);
    step("t5_sys_rst", 1, SYS, 0, 0, 1, 3'd5, 6'b000000, 2'b00, 2'b00, 2'b10);
    fd("t5_br010", BR, 3'd2);
    step("t5_br_halt", 0, BR, 2, 1, 1, 3'd5, 6'b000000, 2'b00, 2'b00, 2'b10);
    step("t5_br_rst", 1, BR, 2, 1, 1, 3'd5, 6'b000000, 2'b00, 2'b00, 2'b10);

    // 4: fetch timeout after 4 waiting cycles -> HALT with fault
    for (int i = 0; i < 4; i++)
      step("t4_fetchwait", 0, OP, 0, 0, 0, 3'd0, 6'b100000, 2'b00, 2'b00, 2'b00);
    step("t4_halt", 0, OP, 0, 0, 0, 3'd5, 6'b000000, 2'b00, 2'b00, 2'b11);
    step("t4_hold", 0, OP, 0, 0, 1, 3'd5, 6'b000000, 2'b00, 2'b00, 2'b11);
    step("t4_rst", 1, OP, 0, 0, 1, 3'd5, 6'b000000, 2'b00, 2'b00, 2'b11);

    // 6: reset during MEM abandons the access
    fd("t6_ld", LD, 3'd2);
    step("t6_exec", 0, LD, 2, 0, 1, 3'd2, 6'b000000, 2'b00, 2'b00, 2'b00);
    step("t6_mem_rst", 1, LD, 2, 0, 1, 3'd3, 6'b000000, 2'b00, 2'b00, 2'b00);
    fd("t6_after", OP, 3'd0);
    step("t6_exec2", 0, OP, 0, 0, 1, 3'd2, 6'b000000, 2'b00, 2'b00, 2'b00);
    step("t6_wb2", 0, OP, 0, 0, 1, 3'd4, 6'b000011, 2'b00, 2'b00, 2'b00);

    // drain the scoreboard with a bounded wait
    for (int i = 0; i < 4 && sb.size() > 0; i++) @(negedge clk);
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain: pending=%0d, required 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
